// File: rtl/trap_entry_sequencer.sv
// trap_entry_sequencer
//   Takes one trap (exception or interrupt) from commit, decides whether it lands in
//   M or S mode using medeleg/mideleg, writes cause, epc, tval and mstatus through the
//   single CSR write port, then pulses a fetch redirect to the trap vector.
//   Only one trap is in flight; trap_ready_o is high only while idle.
//
// Ports
//   cpu_clock_i, cpu_resetn_i       clock, synchronous active-low reset
//   trap_valid_i / trap_ready_o     trap handshake (accept = valid & ready at an edge)
//   trap_irq_i, trap_code_i         interrupt flag and 4-bit cause code
//   trap_pc_i, trap_tval_i          faulting PC and trap value
//   priv_i                          privilege at the time of the trap
//   medeleg_i, mideleg_i            exception / interrupt delegation masks
//   mtvec_i, stvec_i                trap vector bases, [1:0] = mode
//   mstatus_i                       current mstatus
//   csr_wr_en_o/addr_o/data_o       CSR write port, held stable until csr_wr_ready_i
//   redirect_valid_o, redirect_pc_o one-cycle fetch redirect and its target
//   new_priv_o                      privilege after the most recent trap (reset 11)
//
// state    | meaning
// ---------+---------------------------------------------
// IDLE     | ready for a new trap
// W_CAUSE  | writing mcause/scause
// W_EPC    | writing mepc/sepc
// W_TVAL   | writing mtval/stval
// W_STATUS | writing mstatus with the trap-entry updates
// REDIRECT | one-cycle redirect pulse to the trap vector

module trap_entry_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              cpu_clock_i,
  input  logic              cpu_resetn_i,
  input  logic              trap_valid_i,
  output logic              trap_ready_o,
  input  logic              trap_irq_i,
  input  logic [3:0]        trap_code_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  input  logic [XLEN-1:0]   trap_tval_i,
  input  logic [1:0]        priv_i,
  input  logic [15:0]       medeleg_i,
  input  logic [15:0]       mideleg_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   stvec_i,
  input  logic [XLEN-1:0]   mstatus_i,
  output logic              csr_wr_en_o,
  output logic [11:0]       csr_wr_addr_o,
  output logic [XLEN-1:0]   csr_wr_data_o,
  input  logic              csr_wr_ready_i,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic [1:0]        new_priv_o
);

  typedef enum logic [2:0] {
    IDLE, W_CAUSE, W_EPC, W_TVAL, W_STATUS, REDIRECT
  } state_t;

  localparam logic [XLEN-1:0] ALIGN4 = {{(XLEN-2){1'b1}}, 2'b00};

  state_t state_q, state_d;

  logic            irq_q;
  logic [3:0]      code_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tval_q;
  logic [1:0]      priv_q;
  logic            to_s_q;
  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] tvec_q;

  logic            accept;
  logic            deleg;
  logic            to_s;
  logic [3:0]      addr_hi;
  logic [XLEN-1:0] cause_val;
  logic [XLEN-1:0] epc_val;
  logic [XLEN-1:0] status_val;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] vec_pc;

  assign trap_ready_o = (state_q == IDLE);
  assign accept       = trap_valid_i & trap_ready_o;

  // Delegation only lowers the target when the trap was not taken in M.
  assign deleg = trap_irq_i ? mideleg_i[trap_code_i] : medeleg_i[trap_code_i];
  assign to_s  = deleg & (priv_i != 2'b11);

  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_resetn_i) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // Everything the sequence needs is frozen at accept so later input changes are ignored.
  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_resetn_i) begin
      irq_q     <= 1'b0;
      code_q    <= '0;
      pc_q      <= '0;
      tval_q    <= '0;
      priv_q    <= 2'b11;
      to_s_q    <= 1'b0;
      mstatus_q <= '0;
      tvec_q    <= '0;
    end else if (accept) begin
      irq_q     <= trap_irq_i;
      code_q    <= trap_code_i;
      pc_q      <= trap_pc_i;
      tval_q    <= trap_tval_i;
      priv_q    <= priv_i;
      to_s_q    <= to_s;
      mstatus_q <= mstatus_i;
      tvec_q    <= to_s ? stvec_i : mtvec_i;
    end
  end

  // new_priv_o changes on the edge that enters REDIRECT.
  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_resetn_i)
      new_priv_o <= 2'b11;
    else if (state_q == W_STATUS && csr_wr_ready_i)
      new_priv_o <= to_s_q ? 2'b01 : 2'b11;
  end

  assign addr_hi   = to_s_q ? 4'h1 : 4'h3;
  assign cause_val = {irq_q, {(XLEN-5){1'b0}}, code_q};
  assign epc_val   = pc_q & ALIGN4;
  assign vec_base  = tvec_q & ALIGN4;
  // Vectored mode only applies to interrupts; mode 1x falls back to direct.
  assign vec_pc    = (irq_q && tvec_q[1:0] == 2'b01)
                     ? vec_base + {{(XLEN-6){1'b0}}, code_q, 2'b00}
                     : vec_base;

  always_comb begin
    status_val = mstatus_q;
    if (to_s_q) begin
      status_val[5] = mstatus_q[1];
      status_val[1] = 1'b0;
      status_val[8] = priv_q[0];
    end else begin
      status_val[7]     = mstatus_q[3];
      status_val[3]     = 1'b0;
      status_val[12:11] = priv_q;
    end
  end

  always_comb begin
    state_d          = state_q;
    csr_wr_en_o      = 1'b0;
    csr_wr_addr_o    = '0;
    csr_wr_data_o    = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state_q)
      IDLE: begin
        if (trap_valid_i) state_d = W_CAUSE;
      end
      W_CAUSE: begin
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = {addr_hi, 8'h42};
        csr_wr_data_o = cause_val;
        if (csr_wr_ready_i) state_d = W_EPC;
      end
      W_EPC: begin
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = {addr_hi, 8'h41};
        csr_wr_data_o = epc_val;
        if (csr_wr_ready_i) state_d = W_TVAL;
      end
      W_TVAL: begin
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = {addr_hi, 8'h43};
        csr_wr_data_o = tval_q;
        if (csr_wr_ready_i) state_d = W_STATUS;
      end
      W_STATUS: begin
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = 12'h300;
        csr_wr_data_o = status_val;
        if (csr_wr_ready_i) state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = vec_pc;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_entry_sequencer.sv
// Bench for trap_entry_sequencer: a transaction-level model predicts, per accepted trap,
// the list of CSR writes and the redirect; a negedge checker compares every cycle.
module tb_trap_entry_sequencer;

  logic        clk = 1'b0;
  logic        cpu_resetn_i;
  logic        trap_valid_i;
  logic        trap_ready_o;
  logic        trap_irq_i;
  logic [3:0]  trap_code_i;
  logic [31:0] trap_pc_i, trap_tval_i;
  logic [1:0]  priv_i;
  logic [15:0] medeleg_i, mideleg_i;
  logic [31:0] mtvec_i, stvec_i, mstatus_i;
  logic        csr_wr_en_o;
  logic [11:0] csr_wr_addr_o;
  logic [31:0] csr_wr_data_o;
  logic        csr_wr_ready_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [1:0]  new_priv_o;

  trap_entry_sequencer #(.XLEN(32)) dut (
    .cpu_clock_i(clk), .cpu_resetn_i(cpu_resetn_i),
    .trap_valid_i(trap_valid_i), .trap_ready_o(trap_ready_o),
    .trap_irq_i(trap_irq_i), .trap_code_i(trap_code_i),
    .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i), .priv_i(priv_i),
    .medeleg_i(medeleg_i), .mideleg_i(mideleg_i),
    .mtvec_i(mtvec_i), .stvec_i(stvec_i), .mstatus_i(mstatus_i),
    .csr_wr_en_o(csr_wr_en_o), .csr_wr_addr_o(csr_wr_addr_o),
    .csr_wr_data_o(csr_wr_data_o), .csr_wr_ready_i(csr_wr_ready_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .new_priv_o(new_priv_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;
  wr_t         eq[$];
  logic        started = 0;
  logic        redir_pend = 0;
  logic [31:0] pend_pc;
  logic [1:0]  pend_priv;
  logic [1:0]  m_priv = 2'b11;
  logic        acc_evt = 0;
  int          cyc = 0, acc_cyc = 0, last_redir_cyc = -100;
  int          last_lat = 0, last_gap = 0, redir_count = 0;
  logic [11:0] wlog_a[4];
  logic [31:0] wlog_d[4];
  int          wl = 0;
  logic [31:0] lr_pc;
  logic [1:0]  lr_priv;

  function automatic logic [31:0] new_status(logic [31:0] ms, logic s, logic [1:0] p);
    if (s) return (ms & ~32'h0000_0122) | (32'(ms[1]) << 5) | (32'(p[0]) << 8);
    return (ms & ~32'h0000_1888) | (32'(ms[3]) << 7) | (32'(p) << 11);
  endfunction

  task automatic model_accept();
    logic        d, s;
    logic [31:0] tv, base, hi;
    wr_t         w;
    d  = trap_irq_i ? mideleg_i[trap_code_i] : medeleg_i[trap_code_i];
    s  = d && (priv_i != 2'b11);
    hi = s ? 32'h100 : 32'h300;
    w.a = 12'(hi + 32'h42); w.d = (32'(trap_irq_i) << 31) | 32'(trap_code_i); eq.push_back(w);
    w.a = 12'(hi + 32'h41); w.d = trap_pc_i & ~32'd3;                         eq.push_back(w);
    w.a = 12'(hi + 32'h43); w.d = trap_tval_i;                                 eq.push_back(w);
    w.a = 12'h300;          w.d = new_status(mstatus_i, s, priv_i);            eq.push_back(w);
    tv   = s ? stvec_i : mtvec_i;
    base = tv & ~32'd3;
    pend_pc   = (trap_irq_i && (tv % 4) == 1) ? base + 32'(trap_code_i) * 4 : base;
    pend_priv = s ? 2'b01 : 2'b11;
    redir_pend = 1;
  endtask

  always @(negedge clk) begin
    logic ex_en, ex_rv, ex_rdy;
    cyc++;
    acc_evt = 0;
    if (started) begin
      ex_en  = (eq.size() > 0);
      ex_rv  = !ex_en && redir_pend;
      ex_rdy = !ex_en && !redir_pend;
      if (ex_rv) m_priv = pend_priv;
      chk("wr_en", 64'(csr_wr_en_o), 64'(ex_en));
      chk("redirect_valid", 64'(redirect_valid_o), 64'(ex_rv));
      chk("trap_ready", 64'(trap_ready_o), 64'(ex_rdy));
      chk("new_priv", 64'(new_priv_o), 64'(m_priv));
      if (ex_en) begin
        chk("wr_addr", 64'(csr_wr_addr_o), 64'(eq[0].a));
        chk("wr_data", 64'(csr_wr_data_o), 64'(eq[0].d));
      end
      if (ex_rv) begin
        chk("redirect_pc", 64'(redirect_pc_o), 64'(pend_pc));
        lr_pc = pend_pc; lr_priv = pend_priv;
        last_lat = cyc - acc_cyc; last_redir_cyc = cyc; redir_count++;
      end
    end
    if (!cpu_resetn_i) begin
      eq.delete(); redir_pend = 0; m_priv = 2'b11; started = 1;
    end else if (started) begin
      if (eq.size() > 0) begin
        if (csr_wr_ready_i) begin
          if (wl < 4) begin wlog_a[wl] = eq[0].a; wlog_d[wl] = eq[0].d; end
          wl++;
          void'(eq.pop_front());
        end
      end else if (redir_pend) begin
        redir_pend = 0;
      end else if (trap_valid_i) begin
        model_accept();
        acc_evt = 1; wl = 0;
        last_gap = cyc - last_redir_cyc; acc_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_trap(logic irq, logic [3:0] code, logic [31:0] pc, logic [31:0] tval,
                          logic [1:0] p, logic [15:0] med, logic [15:0] mid,
                          logic [31:0] mt, logic [31:0] st, logic [31:0] ms);
    trap_irq_i = irq; trap_code_i = code; trap_pc_i = pc; trap_tval_i = tval;
    priv_i = p; medeleg_i = med; mideleg_i = mid; mtvec_i = mt; stvec_i = st; mstatus_i = ms;
  endtask

  task automatic wait_acc();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (acc_evt) return;
    end
    chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_redir(input int n0);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (redir_count > n0) return;
    end
    chk("redirect_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_one();
    int rc;
    rc = redir_count;
    trap_valid_i = 1;
    wait_acc();
    trap_valid_i = 0;
    wait_redir(rc);
    @(posedge clk); #1;
  endtask

  initial begin
    int rc;
    logic [1:0] privs[3];
    privs[0] = 2'b00; privs[1] = 2'b01; privs[2] = 2'b11;
    cpu_resetn_i = 0; trap_valid_i = 0; csr_wr_ready_i = 1;
    set_trap(0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 cpu_resetn_i = 1;
    chk("rst_ready", 64'(trap_ready_o), 64'd1);
    chk("rst_en", 64'(csr_wr_en_o), 64'd0);
    chk("rst_addr", 64'(csr_wr_addr_o), 64'd0);
    chk("rst_data", 64'(csr_wr_data_o), 64'd0);
    chk("rst_rpc", 64'(redirect_pc_o), 64'd0);
    chk("rst_priv", 64'(new_priv_o), 64'd3);

    // delegated exception from U lands in S
    set_trap(0, 4'd2, 32'h1006, 32'hDEAD, 2'b00, 16'h0004, 0, 32'h0000_0500, 32'h0000_4000, 32'h0000_000A);
    run_one();
    chk("t1_a0", 64'(wlog_a[0]), 64'h142); chk("t1_d0", 64'(wlog_d[0]), 64'h2);
    chk("t1_a1", 64'(wlog_a[1]), 64'h141); chk("t1_d1", 64'(wlog_d[1]), 64'h1004);
    chk("t1_a2", 64'(wlog_a[2]), 64'h143); chk("t1_d2", 64'(wlog_d[2]), 64'hDEAD);
    chk("t1_a3", 64'(wlog_a[3]), 64'h300); chk("t1_d3", 64'(wlog_d[3]), 64'h28);
    chk("t1_pc", 64'(lr_pc), 64'h4000); chk("t1_priv", 64'(new_priv_o), 64'h1);
    chk("t1_lat", 64'(last_lat), 64'd5);

    // same delegation but taken in M stays in M
    set_trap(0, 4'd2, 32'h2000, 32'h1, 2'b11, 16'h0004, 0, 32'h0000_0100, 32'h0000_4000, 32'h0000_0008);
    run_one();
    chk("t2_a0", 64'(wlog_a[0]), 64'h342); chk("t2_a1", 64'(wlog_a[1]), 64'h341);
    chk("t2_a2", 64'(wlog_a[2]), 64'h343); chk("t2_d3", 64'(wlog_d[3]), 64'h1880);
    chk("t2_priv", 64'(lr_priv), 64'h3);

    // vectored and direct interrupt
    set_trap(1, 4'd7, 32'h3000, 32'h0, 2'b00, 0, 0, 32'h8000_0001, 0, 0);
    run_one();
    chk("t3_cause", 64'(wlog_d[0]), 64'h8000_0007); chk("t3_pc", 64'(lr_pc), 64'h8000_001C);
    set_trap(1, 4'd7, 32'h3000, 32'h0, 2'b00, 0, 0, 32'h8000_0000, 0, 0);
    run_one();
    chk("t3b_pc", 64'(lr_pc), 64'h8000_0000);

    // 3 stall cycles in W_EPC
    set_trap(0, 4'd5, 32'h4444, 32'h55, 2'b01, 16'hFFFF, 0, 0, 32'h2000, 32'h2);
    rc = redir_count;
    trap_valid_i = 1;
    wait_acc();
    trap_valid_i = 0;
    @(posedge clk); #1 csr_wr_ready_i = 0;
    repeat (3) @(posedge clk);
    #1 csr_wr_ready_i = 1;
    wait_redir(rc);
    chk("t4_lat", 64'(last_lat), 64'd8);
    chk("t4_priv", 64'(lr_priv), 64'h1);

    // reset during W_TVAL abandons the trap
    set_trap(0, 4'd3, 32'h5000, 32'h66, 2'b00, 16'hFFFF, 0, 0, 32'h3000, 0);
    trap_valid_i = 1;
    wait_acc();
    trap_valid_i = 0;
    @(posedge clk); @(posedge clk);
    #1 cpu_resetn_i = 0; csr_wr_ready_i = 0;
    @(posedge clk);
    #1 cpu_resetn_i = 1; csr_wr_ready_i = 1;
    rc = redir_count;
    chk("t5_en", 64'(csr_wr_en_o), 64'd0);
    chk("t5_ready", 64'(trap_ready_o), 64'd1);
    chk("t5_priv", 64'(new_priv_o), 64'd3);
    repeat (10) @(posedge clk);
    #1 chk("t5_noredir", 64'(redir_count), 64'(rc));

    // back-to-back with valid held, inputs changed mid-sequence
    set_trap(0, 4'd1, 32'h6000, 32'h77, 2'b11, 0, 0, 32'h0000_0600, 0, 32'h8);
    trap_valid_i = 1;
    wait_acc();
    set_trap(1, 4'd9, 32'h7000, 32'h88, 2'b00, 0, 16'h0200, 0, 32'h0000_0701, 32'h2);
    wait_acc();
    trap_valid_i = 0;
    chk("t6_gap", 64'(last_gap), 64'd1);
    chk("t6_first_pc", 64'(lr_pc), 64'h600);
    rc = redir_count;
    wait_redir(rc);
    chk("t6_second_pc", 64'(lr_pc), 64'h724);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (acc_evt || !trap_valid_i) trap_valid_i = ($urandom % 3 == 0);
      trap_irq_i   = 1'($urandom);
      trap_code_i  = 4'($urandom);
      trap_pc_i    = $urandom;
      trap_tval_i  = $urandom;
      priv_i       = privs[$urandom % 3];
      medeleg_i    = 16'($urandom);
      mideleg_i    = 16'($urandom);
      mtvec_i      = $urandom;
      stvec_i      = $urandom;
      mstatus_i    = $urandom;
      csr_wr_ready_i = ($urandom % 4 != 0);
      cpu_resetn_i   = ($urandom % 300 != 0);
      @(posedge clk); #1;
    end
    cpu_resetn_i = 1; trap_valid_i = 0; csr_wr_ready_i = 1;
    repeat (20) @(posedge clk);
    #1 chk("end_idle", 64'(trap_ready_o), 64'd1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
